// File: rtl/reed_solomon_encoder.sv
// Systematic byte-serial RS encoder over GF(2^8): message bytes pass through with one
// cycle of latency, then N-K parity bytes are shifted out of the LFSR remainder.
module reed_solomon_encoder #(
   parameter int         N         = 255,
   parameter int         K         = 239,
   parameter logic [8:0] PRIM_POLY = 9'h11D,
   parameter int         FCR       = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       parity_out,
   output logic       last_out
);

   localparam int NPAR = N - K;
   localparam int CW   = $clog2(N + 1);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // g(x) = prod (x + a^(FCR+i)); index = power of x, GEN[NPAR] = 1
   function automatic logic [NPAR:0][7:0] gen_poly();
      logic [NPAR:0][7:0] g;
      logic [7:0]         root;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
      for (int i = 0; i < NPAR; i++) begin
         for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
         g[0] = gf_mul(g[0], root);
         root = gf_mul(root, 8'h02);
      end
      return g;
   endfunction

   localparam logic [NPAR:0][7:0] GEN = gen_poly();

   typedef enum logic {MSG, PAR} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [NPAR-1:0][7:0] r, r_sh, prod;
   logic [7:0]           fb;
   logic                 accept, par;

   assign ready_in = (state == MSG);
   assign par      = (state == PAR);
   assign accept   = valid_in && ready_in;
   assign fb       = data_in ^ r[NPAR-1];
   assign r_sh     = {r[NPAR-2:0], 8'h00};

   // constant-coefficient multipliers: each collapses to a fixed XOR network
   for (genvar i = 0; i < NPAR; i++) begin : g_mul
      assign prod[i] = gf_mul(fb, GEN[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= MSG;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         MSG: if (valid_in) begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(K - 1)) state_nxt = PAR;
         end
         PAR: if (cnt == CW'(N - 1)) begin
            cnt_nxt   = '0;
            state_nxt = MSG;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
         default: state_nxt = MSG;
      endcase
   end

   // 2T shifts during PAR drain the remainder, leaving all regs zero for the next codeword
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r <= '0;
      else if (accept) r <= r_sh ^ prod;
      else if (par)    r <= r_sh;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= 8'h00;
         valid_out  <= 1'b0;
         parity_out <= 1'b0;
         last_out   <= 1'b0;
      end else begin
         valid_out  <= accept || par;
         parity_out <= par;
         last_out   <= par && (cnt == CW'(N - 1));
         if (accept)   data_out <= data_in;
         else if (par) data_out <= r[NPAR-1];
      end
   end

endmodule

// File: tb/tb_reed_solomon_encoder.sv
// Scoreboard bench for the RS(255,239) encoder: stimulus queues expected bytes, a
// negedge monitor pops/compares and checks codeword syndromes and ready_in timing.
module tb_reed_solomon_encoder;

   localparam int N  = 255;
   localparam int K  = 239;
   localparam int NP = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       parity_out;
   logic       last_out;

   always #5 clk = ~clk;

   reed_solomon_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .parity_out (parity_out),
      .last_out   (last_out)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       last;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // g(x) for RS(255,239), FCR=0, 0x11D; index = power of x (g[0] = a^120 = 0x3B)
   logic [7:0] gtab [17] = '{8'd59, 8'd36, 8'd50, 8'd98, 8'd229, 8'd41, 8'd65, 8'd163,
                             8'd8, 8'd30, 8'd209, 8'd68, 8'd189, 8'd104, 8'd13, 8'd59, 8'd1};

   logic [7:0] cur_msg [K];
   logic [7:0] cw [N];
   int         cw_n    = 0;
   int         rdy_low = 0;
   int         gaps    = 0;
   bit         gap_arm = 0;
   bit         seen_vo = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] gpow(input int e);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 0; i < e; i++) v = gmul(v, 8'h02);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // long division of m(x)*x^16 by g(x); remainder is the parity, highest power first
   task automatic model_parity(output logic [7:0] p [NP]);
      logic [7:0] c [N];
      logic [7:0] f;
      for (int i = 0; i < N; i++) c[i] = (i < K) ? cur_msg[i] : 8'h00;
      for (int i = 0; i < K; i++) begin
         f = c[i];
         if (f != 0)
            for (int j = 1; j <= NP; j++) c[i+j] = c[i+j] ^ gmul(f, gtab[NP-j]);
      end
      for (int i = 0; i < NP; i++) p[i] = c[K+i];
   endtask

   // monitor: pops on every valid_out, checks whole-codeword properties on last_out
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] s;
      logic [7:0] aj;
      if (reset) begin
         cw_n    = 0;
         rdy_low = 0;
      end else begin
         if (!ready_in) rdy_low++;
         if (gap_arm && seen_vo && !valid_out && q.size() > 0) gaps++;
         if (valid_out) begin
            seen_vo = 1;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got data 0x%0h, expected no output", data_out);
            end else begin
               e = q.pop_front();
               chk("data_out", int'(data_out), int'(e.data));
               chk("parity_out", int'(parity_out), int'(e.par));
               chk("last_out", int'(last_out), int'(e.last));
            end
            if (cw_n < N) cw[cw_n] = data_out;
            cw_n++;
            if (last_out) begin
               chk("codeword_len", cw_n, N);
               if (cw_n == N)
                  for (int j = 0; j < NP; j++) begin
                     aj = gpow(j);
                     s  = 0;
                     for (int i = 0; i < N; i++) s = gmul(s, aj) ^ cw[i];
                     chk($sformatf("syndrome%0d", j), int'(s), 0);
                  end
               chk("ready_low_cycles", rdy_low, NP);
               cw_n    = 0;
               rdy_low = 0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, output bit acc_last);
      bit acc;
      int waited;
      if (gap > 0) begin
         valid_in = 0;
         repeat (gap) @(posedge clk);
         #1;
      end
      valid_in = 1;
      data_in  = b;
      waited   = 0;
      forever begin
         acc      = ready_in;
         acc_last = last_out;
         @(posedge clk);
         #1;
         if (acc) break;
         waited++;
         if (waited > 64) begin
            $display("FAIL ready_timeout: ready_in low for %0d cycles, expected at most %0d", waited, NP);
            errors++;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "stalled");
         end
      end
      q.push_back('{data: b, par: 1'b0, last: 1'b0});
   endtask

   task automatic send_msg(input int nbytes, input bit use_gaps, input bit hand_par,
                           input bit chk_first);
      logic [7:0] p [NP];
      bit         acc_last;
      int         gap;
      for (int i = 0; i < nbytes; i++) begin
         gap = 0;
         if (use_gaps && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 3));
         send_byte(cur_msg[i], gap, acc_last);
         if (i == 0 && chk_first) chk("accept_in_last_cycle", int'(acc_last), 1);
      end
      if (nbytes == K) begin
         if (hand_par) for (int i = 0; i < NP; i++) p[i] = gtab[NP-1-i];
         else          model_parity(p);
         for (int i = 0; i < NP; i++)
            q.push_back('{data: p[i], par: 1'b1, last: (i == NP - 1)});
      end
   endtask

   task automatic drain();
      int w;
      valid_in = 0;
      w = 0;
      while (q.size() > 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      chk("drain_leftover", q.size(), 0);
      q.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rand_msg();
      for (int i = 0; i < K; i++) cur_msg[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1;
      valid_in = 0;
      data_in  = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready_in", int'(ready_in), 1);
      chk("reset_valid_out", int'(valid_out), 0);
      chk("reset_data_out", int'(data_out), 0);
      chk("reset_parity_out", int'(parity_out), 0);
      chk("reset_last_out", int'(last_out), 0);
      reset = 0;
      @(posedge clk);
      #1;

      // all-zero message, valid_in held high
      for (int i = 0; i < K; i++) cur_msg[i] = 8'h00;
      send_msg(K, 0, 0, 0);
      drain();

      // single 1 in the last position: parity is g(x) itself
      cur_msg[K-1] = 8'h01;
      send_msg(K, 0, 1, 0);
      drain();
      chk("g0_is_a120", int'(gtab[0]), int'(gpow(120)));

      // random messages with random valid_in gaps
      for (int m = 0; m < 5; m++) begin
         rand_msg();
         send_msg(K, 1, 0, 0);
         drain();
      end

      // reset in the middle of a codeword
      rand_msg();
      send_msg(120, 0, 0, 0);
      reset = 1;
      valid_in = 0;
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      chk("midreset_valid_out", int'(valid_out), 0);
      chk("midreset_ready_in", int'(ready_in), 1);
      repeat (5) @(posedge clk);
      #1;
      rand_msg();
      send_msg(K, 0, 0, 0);
      drain();

      // back-to-back codewords, valid_in never dropped
      gaps    = 0;
      seen_vo = 0;
      gap_arm = 1;
      for (int m = 0; m < 3; m++) begin
         rand_msg();
         send_msg(K, 0, 0, m > 0);
      end
      drain();
      gap_arm = 0;
      chk("stream_gaps", gaps, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
